// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and common-data-bus broadcast signals.
// The master side is the pool of functional units; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 4,
  parameter int ROB_DEPTH = 4
);
  localparam int TAGW = $clog2(ROB_DEPTH);
  localparam int SRCW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0]           fu_ready;
  logic [NUM_FU-1:0][TAGW-1:0] fu_rob;
  logic [NUM_FU-1:0][4:0]      fu_rd_s;
  logic [NUM_FU-1:0][31:0]     fu_rd_v;

  logic                        cdb_valid;
  logic [TAGW-1:0]             cdb_rob;
  logic [4:0]                  cdb_rd_s;
  logic [31:0]                 cdb_rd_v;
  logic [SRCW-1:0]             cdb_src;

  modport master (
    output fu_valid, fu_rob, fu_rd_s, fu_rd_v,
    input  fu_ready, cdb_valid, cdb_rob, cdb_rd_s, cdb_rd_v, cdb_src
  );

  modport slave (
    input  fu_valid, fu_rob, fu_rd_s, fu_rd_v,
    output fu_ready, cdb_valid, cdb_rob, cdb_rd_s, cdb_rd_v, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one holding buffer per functional
// unit, one broadcast per cycle, all buffered results dropped on flush or reset.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int TAGW = $clog2(ROB_DEPTH);
  localparam int SRCW = $clog2(NUM_FU);

  logic            buf_valid_reg [NUM_FU];
  logic [TAGW-1:0] buf_rob_reg   [NUM_FU];
  logic [4:0]      buf_rd_s_reg  [NUM_FU];
  logic [31:0]     buf_rd_v_reg  [NUM_FU];

  logic [SRCW-1:0]   rr_ptr_reg;
  logic [SRCW-1:0]   rr_ptr_next;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] xfer;
  logic              grant_valid;
  logic [SRCW-1:0]   grant_idx;
  logic [SRCW:0]     scan_sum;
  logic [SRCW-1:0]   scan_idx;
  logic              stall;

  assign stall = rst | flush;

  // Scan from rr_ptr upward with wrap; the sum is one bit wider so the wrap
  // compare works for any NUM_FU, not only powers of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (SRCW+1)'(k);
      if (scan_sum >= (SRCW+1)'(NUM_FU)) begin
        scan_sum = scan_sum - (SRCW+1)'(NUM_FU);
      end
      scan_idx = scan_sum[SRCW-1:0];
      if (!grant_valid && !stall && buf_valid_reg[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (stall) begin
      rr_ptr_next = '0;
    end else if (grant_valid) begin
      rr_ptr_next = (grant_idx == SRCW'(NUM_FU - 1)) ? '0 : grant_idx + SRCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    bus.cdb_valid = grant_valid;
    bus.cdb_rob   = '0;
    bus.cdb_rd_s  = '0;
    bus.cdb_rd_v  = '0;
    bus.cdb_src   = '0;
    if (grant_valid) begin
      bus.cdb_rob  = buf_rob_reg[grant_idx];
      bus.cdb_rd_s = buf_rd_s_reg[grant_idx];
      bus.cdb_rd_v = buf_rd_v_reg[grant_idx];
      bus.cdb_src  = grant_idx;
    end
  end

  assign bus.fu_ready = ready;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unit
      assign grant[gi] = grant_valid && (grant_idx == SRCW'(gi));
      // Ready comes only from registered state and grant, never from fu_valid.
      assign ready[gi] = ~stall & (~buf_valid_reg[gi] | grant[gi]);
      assign xfer[gi]  = bus.fu_valid[gi] & ready[gi];

      always_ff @(posedge clk) begin
        if (stall) begin
          buf_valid_reg[gi] <= 1'b0;
        end else if (xfer[gi]) begin
          buf_valid_reg[gi] <= 1'b1;
        end else if (grant[gi]) begin
          buf_valid_reg[gi] <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (xfer[gi]) begin
          buf_rob_reg[gi]  <= bus.fu_rob[gi];
          buf_rd_s_reg[gi] <= bus.fu_rd_s[gi];
          buf_rd_v_reg[gi] <= bus.fu_rd_v[gi];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the holding buffers.
module tb_cdb_arbiter;
  localparam int NUM_FU    = 4;
  localparam int ROB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .ROB_DEPTH(ROB_DEPTH)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  rob;
    logic [4:0]  rd;
    logic [31:0] v;
  } res_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  valid;
    logic [1:0]  rob;
    logic [4:0]  rd;
    logic [31:0] vbase;
    logic        e_valid;
    logic [1:0]  e_src;
    logic [1:0]  e_rob;
    logic [31:0] e_v;
    logic [3:0]  e_ready;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each unit holds at most one waiting result in a queue.
  res_t held [NUM_FU][$];
  int   m_ptr = 0;
  int   m_grant;
  logic [3:0] m_ready;

  logic        s_valid;
  logic [1:0]  s_src;
  logic [1:0]  s_rob;
  logic [4:0]  s_rd_s;
  logic [31:0] s_rd_v;
  logic [3:0]  s_ready;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_comb();
    m_grant = -1;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        int u = (m_ptr + k) % NUM_FU;
        if (m_grant < 0 && held[u].size() > 0) m_grant = u;
      end
    end
    for (int u = 0; u < NUM_FU; u++) begin
      m_ready[u] = !rst && !flush && (held[u].size() == 0 || m_grant == u);
    end
  endfunction

  function automatic void model_edge();
    if (rst || flush) begin
      for (int u = 0; u < NUM_FU; u++) held[u].delete();
      m_ptr = 0;
    end else begin
      if (m_grant >= 0) begin
        void'(held[m_grant].pop_front());
        m_ptr = (m_grant + 1) % NUM_FU;
      end
      for (int u = 0; u < NUM_FU; u++) begin
        if (bus.fu_valid[u] && m_ready[u]) begin
          held[u].push_back('{rob: bus.fu_rob[u], rd: bus.fu_rd_s[u], v: bus.fu_rd_v[u]});
        end
      end
    end
  endfunction

  // One clock cycle: inputs already driven; sample at negedge, compare, advance.
  task automatic step();
    logic        e_valid;
    logic [31:0] e_src;
    logic [31:0] e_rob;
    logic [31:0] e_rd;
    logic [31:0] e_v;
    model_comb();
    @(negedge clk);
    s_valid = bus.cdb_valid;
    s_src   = bus.cdb_src;
    s_rob   = bus.cdb_rob;
    s_rd_s  = bus.cdb_rd_s;
    s_rd_v  = bus.cdb_rd_v;
    s_ready = bus.fu_ready;
    e_valid = 1'b0; e_src = 0; e_rob = 0; e_rd = 0; e_v = 0;
    if (m_grant >= 0) begin
      e_valid = 1'b1;
      e_src   = m_grant;
      e_rob   = 32'(held[m_grant][0].rob);
      e_rd    = 32'(held[m_grant][0].rd);
      e_v     = held[m_grant][0].v;
    end
    check("model_cdb_valid", 32'(s_valid), 32'(e_valid));
    check("model_cdb_src", 32'(s_src), e_src);
    check("model_cdb_rob", 32'(s_rob), e_rob);
    check("model_cdb_rd_s", 32'(s_rd_s), e_rd);
    check("model_cdb_rd_v", s_rd_v, e_v);
    check("model_fu_ready", 32'(s_ready), 32'(m_ready));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] v, input logic [1:0] rob, input logic [4:0] rd,
                       input logic [31:0] vbase);
    bus.fu_valid = v;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_rob[i]  = rob;
      bus.fu_rd_s[i] = rd;
      bus.fu_rd_v[i] = vbase + 32'(i);
    end
  endtask

  initial begin
    int   seq [NUM_FU];
    int   cnt [NUM_FU];
    int   last_src;
    int   load;
    logic [3:0] want;

    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b0, 2'd0, 2'd0, 32'h0,        4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b0, 2'd0, 2'd0, 32'h0,        4'b1111};
    vecs[2]  = '{1'b0, 1'b0, 4'b0100, 2'd3, 5'd5, 32'hDEADBEED, 1'b0, 2'd0, 2'd0, 32'h0,        4'b1111};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b1, 2'd2, 2'd3, 32'hDEADBEEF, 4'b1111};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b0, 2'd0, 2'd0, 32'h0,        4'b1111};
    vecs[5]  = '{1'b1, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b0, 2'd0, 2'd0, 32'h0,        4'b0000};
    vecs[6]  = '{1'b0, 1'b0, 4'b1111, 2'd1, 5'd7, 32'h100,      1'b0, 2'd0, 2'd0, 32'h0,        4'b1111};
    vecs[7]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b1, 2'd0, 2'd1, 32'h100,      4'b0001};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b1, 2'd1, 2'd1, 32'h101,      4'b0011};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b1, 2'd2, 2'd1, 32'h102,      4'b0111};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b1, 2'd3, 2'd1, 32'h103,      4'b1111};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 2'd0, 5'd0, 32'h0,        1'b0, 2'd0, 2'd0, 32'h0,        4'b1111};

    rst   = 1'b1;
    flush = 1'b0;
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      rst   = vecs[i].rst;
      flush = vecs[i].flush;
      offer(vecs[i].valid, vecs[i].rob, vecs[i].rd, vecs[i].vbase);
      step();
      check("vec_cdb_valid", 32'(s_valid), 32'(vecs[i].e_valid));
      check("vec_cdb_src", 32'(s_src), 32'(vecs[i].e_src));
      check("vec_cdb_rob", 32'(s_rob), 32'(vecs[i].e_rob));
      check("vec_cdb_rd_v", s_rd_v, vecs[i].e_v);
      check("vec_fu_ready", 32'(s_ready), 32'(vecs[i].e_ready));
      $display("vec %0d: cdb_valid=%0d src=%0d rob=%0d v=0x%08h ready=%b",
               i, s_valid, s_src, s_rob, s_rd_v, s_ready);
    end

    // Unit 1 streams eight results alone: one broadcast per cycle, never stalled.
    for (int n = 1; n <= 8; n++) begin
      offer(4'b0010, 2'(n), 5'(n), 32'(n - 1));
      step();
      check("stream_ready1", 32'(s_ready[1]), 32'd1);
      if (n > 1) begin
        check("stream_valid", 32'(s_valid), 32'd1);
        check("stream_v", s_rd_v, 32'(n - 1));
      end
    end
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("stream_last_valid", 32'(s_valid), 32'd1);
    check("stream_last_v", s_rd_v, 32'd8);
    $display("stream: last broadcast v=%0d", s_rd_v);

    // Units 0 and 3 stream together: grants must alternate.
    want = 4'b1001;
    last_src = -1;
    for (int u = 0; u < NUM_FU; u++) begin seq[u] = 0; cnt[u] = 0; end
    for (int c = 0; c < 16; c++) begin
      bus.fu_valid = want;
      for (int u = 0; u < NUM_FU; u++) begin
        bus.fu_rob[u]  = 2'(seq[u]);
        bus.fu_rd_s[u] = 5'(u);
        bus.fu_rd_v[u] = 32'((u << 16) | seq[u]);
      end
      step();
      if (s_valid) begin
        check("pair_src_set", 32'(s_src == 2'd0 || s_src == 2'd3), 32'd1);
        if (last_src >= 0) check("pair_alternate", 32'(int'(s_src) != last_src), 32'd1);
        last_src = int'(s_src);
        cnt[s_src]++;
      end
      for (int u = 0; u < NUM_FU; u++) begin
        if (want[u] && s_ready[u]) begin
          seq[u]++;
          if (c >= 10) want[u] = 1'b0;
        end
      end
    end
    check("pair_count0", 32'(cnt[0] >= 4), 32'd1);
    check("pair_count3", 32'(cnt[3] >= 4), 32'd1);
    $display("pair: grants unit0=%0d unit3=%0d", cnt[0], cnt[3]);
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) step();

    // Flush with units 1 and 2 buffered while unit 0 offers.
    offer(4'b0110, 2'd0, 5'd0, 32'h200);
    step();
    flush = 1'b1;
    offer(4'b0001, 2'd1, 5'd1, 32'h300);
    step();
    check("flush_valid", 32'(s_valid), 32'd0);
    check("flush_ready", 32'(s_ready), 32'd0);
    flush = 1'b0;
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("post_flush_valid", 32'(s_valid), 32'd0);
    check("post_flush_ready", 32'(s_ready), 32'hF);
    step();
    check("post_flush_empty", 32'(s_valid), 32'd0);
    offer(4'b0001, 2'd1, 5'd1, 32'h300);
    step();
    check("reoffer_ready0", 32'(s_ready[0]), 32'd1);
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("reoffer_valid", 32'(s_valid), 32'd1);
    check("reoffer_src", 32'(s_src), 32'd0);
    check("reoffer_v", s_rd_v, 32'h300);
    $display("flush: re-offered result broadcast src=%0d v=0x%0h", s_src, s_rd_v);

    // Reset with buffers 0,1,3 full and pointer at 2; pointer must restart at 0.
    offer(4'b0010, 2'd2, 5'd2, 32'h400);
    step();
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("ptr_setup_src", 32'(s_src), 32'd1);
    offer(4'b1011, 2'd3, 5'd3, 32'h500);
    step();
    rst = 1'b1;
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("rst_mid_valid", 32'(s_valid), 32'd0);
    check("rst_mid_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(s_valid), 32'd0);
    check("post_rst_ready", 32'(s_ready), 32'hF);
    offer(4'b1010, 2'd0, 5'd4, 32'h600);
    step();
    offer(4'b0000, 2'd0, 5'd0, 32'h0);
    step();
    check("post_rst_first_src", 32'(s_src), 32'd1);
    check("post_rst_first_v", s_rd_v, 32'h601);
    step();
    check("post_rst_second_src", 32'(s_src), 32'd3);
    check("post_rst_second_v", s_rd_v, 32'h603);
    step();
    $display("reset: post-reset grants 1 then 3");

    // Random traffic with occasional flush and reset; units hold until accepted.
    load = 5;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) load = $urandom_range(1, 10);
      rst   = ($urandom_range(0, 199) == 0);
      flush = !rst && ($urandom_range(0, 39) == 0);
      for (int u = 0; u < NUM_FU; u++) begin
        if (!bus.fu_valid[u] && $urandom_range(0, 9) < load) begin
          bus.fu_valid[u] = 1'b1;
          bus.fu_rob[u]   = 2'($urandom);
          bus.fu_rd_s[u]  = 5'($urandom);
          bus.fu_rd_v[u]  = $urandom;
        end
      end
      step();
      for (int u = 0; u < NUM_FU; u++) begin
        if (bus.fu_valid[u] && s_ready[u]) bus.fu_valid[u] = 1'b0;
      end
    end
    rst   = 1'b0;
    flush = 1'b0;
    $display("random: 1500 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
